// File: rtl/div_sched.sv
// div_sched: run-time controller and generator for an even-ratio divided clock.
// A new ratio arrives over a valid/ready port. Ratio changes and stop requests
// take effect only at the end of a high phase, so the output never produces a
// runt pulse.
module div_sched #(
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 div_en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    output logic                 cfg_err,
    output logic                 div_clk_out,
    output logic                 period_done,
    output logic [CNT_WIDTH-1:0] cur_div,
    output logic                 busy
);

    // Half-period quantities need one bit less than the full ratio.
    localparam int HW = CNT_WIDTH - 1;
    localparam logic [HW-1:0] DEFAULT_HALF = HW'(DEFAULT_DIV / 2);

    generate
        if ((DEFAULT_DIV < 2) || ((DEFAULT_DIV % 2) != 0)) begin : g_bad_default
            $error("div_sched: DEFAULT_DIV must be even and >= 2");
        end
    endgenerate

    // SWITCH means "running, with a new ratio waiting for the next boundary".
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t        r_state, w_state_next;
    logic [HW-1:0] r_cnt, w_cnt_next;
    logic [HW-1:0] r_cur_half, w_cur_half_next;
    logic [HW-1:0] r_pend_half, w_pend_half_next;
    logic          r_out, w_out_next;
    logic          r_err, w_err_next;
    logic          r_pd, w_pd_next;

    logic          w_xfer;
    logic          w_legal;
    logic [HW-1:0] w_new_half;
    logic          w_half_end;
    logic          w_boundary;

    // Handshake decode and phase-end detection.
    assign cfg_ready  = (r_state != SWITCH);
    assign w_xfer     = cfg_valid && cfg_ready;
    assign w_legal    = (cfg_div[0] == 1'b0) && (cfg_div != '0);
    assign w_new_half = cfg_div[CNT_WIDTH-1:1];
    assign w_half_end = (r_cnt == (r_cur_half - HW'(1)));
    assign w_boundary = (r_state != IDLE) && w_half_end && r_out;

    // Next-state logic: counting, toggling, ratio loading and boundary actions.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_cur_half_next  = r_cur_half;
        w_pend_half_next = r_pend_half;
        w_out_next       = r_out;
        w_err_next       = w_xfer && !w_legal;
        w_pd_next        = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                w_out_next = 1'b0;
                // Loading directly lets a same-cycle start use the new ratio.
                if (w_xfer && w_legal) begin
                    w_cur_half_next = w_new_half;
                end
                if (div_en) begin
                    w_state_next = RUN;
                end
            end
            RUN, SWITCH: begin
                if (w_half_end) begin
                    w_cnt_next = '0;
                    w_out_next = ~r_out;
                end else begin
                    w_cnt_next = r_cnt + HW'(1);
                end
                if (w_boundary) begin
                    w_pd_next    = 1'b1;
                    w_state_next = div_en ? RUN : IDLE;
                    if (r_state == SWITCH) begin
                        w_cur_half_next = r_pend_half;
                    end
                end
                // Only RUN can see a transfer (cfg_ready is low in SWITCH).
                // A ratio taken in a boundary cycle waits for the next
                // boundary, unless the generator is stopping now, in which
                // case it is loaded like an idle-time ratio.
                if ((r_state == RUN) && w_xfer && w_legal) begin
                    if (w_boundary && !div_en) begin
                        w_cur_half_next = w_new_half;
                    end else begin
                        w_pend_half_next = w_new_half;
                        w_state_next     = SWITCH;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
                w_out_next   = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset to the idle, default-ratio state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cur_half  <= DEFAULT_HALF;
            r_pend_half <= '0;
            r_out       <= 1'b0;
            r_err       <= 1'b0;
            r_pd        <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_cur_half  <= w_cur_half_next;
            r_pend_half <= w_pend_half_next;
            r_out       <= w_out_next;
            r_err       <= w_err_next;
            r_pd        <= w_pd_next;
        end
    end

    assign div_clk_out = r_out;
    assign period_done = r_pd;
    assign cfg_err     = r_err;
    assign cur_div     = {r_cur_half, 1'b0};
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed stimulus for div_sched, checked every cycle against a
// position-in-period behavioural model plus hand-computed literal expectations.
module tb_div_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_div = 16'd0;
    logic        cfg_err;
    logic        div_clk_out;
    logic        period_done;
    logic [15:0] cur_div;
    logic        busy;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Model state: whether a period is running, cycle position within it,
    // ratio in force, pending ratio (-1 = none) and the one-cycle pulses.
    bit m_active;
    int m_pos;
    int m_div;
    int m_pend;
    bit m_err;
    bit m_pd;

    always #5 clk = ~clk;

    div_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_en      (div_en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_div     (cfg_div),
        .cfg_err     (cfg_err),
        .div_clk_out (div_clk_out),
        .period_done (period_done),
        .cur_div     (cur_div),
        .busy        (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // One clock edge as seen by the model.
    task automatic model_step();
        bit rdy, xfer, legal, bnd;
        int n;
        n     = int'(cfg_div);
        rdy   = (m_pend < 0);
        xfer  = cfg_valid && rdy;
        legal = (n >= 2) && ((n % 2) == 0);
        m_err = xfer && !legal;
        m_pd  = 1'b0;
        if (!m_active) begin
            if (xfer && legal) m_div = n;
            if (div_en) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else begin
            bnd = (m_pos == m_div - 1);
            if (bnd) begin
                m_pd  = 1'b1;
                m_pos = 0;
                if (m_pend >= 0) begin
                    m_div  = m_pend;
                    m_pend = -1;
                end
                m_active = div_en;
                if (xfer && legal) begin
                    if (div_en) m_pend = n;
                    else        m_div  = n;
                end
            end else begin
                m_pos++;
                if (xfer && legal) m_pend = n;
            end
        end
    endtask

    // Model update on every clock edge or asynchronous reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 1'b0;
                m_pos    = 0;
                m_div    = 8;
                m_pend   = -1;
                m_err    = 1'b0;
                m_pd     = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("cyc_out",   32'(div_clk_out), 32'(m_active && (m_pos >= m_div / 2)));
                chk("cyc_pd",    32'(period_done), 32'(m_pd));
                chk("cyc_err",   32'(cfg_err),     32'(m_err));
                chk("cyc_div",   32'(cur_div),     32'(m_div));
                chk("cyc_busy",  32'(busy),        32'(m_active));
                chk("cyc_ready", 32'(cfg_ready),   32'(m_pend < 0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input int maxc);
        int n = 0;
        while ((div_clk_out !== 1'b1) && (n < maxc)) begin
            tick();
            n++;
        end
        chk("wait_rise", 32'(div_clk_out), 32'd1);
    endtask

    task automatic wait_cur(input int v, input int maxc);
        int n = 0;
        while ((int'(cur_div) != v) && (n < maxc)) begin
            tick();
            n++;
        end
        chk("wait_cur", 32'(cur_div), 32'(v));
    endtask

    task automatic send(input int n);
        cfg_valid = 1'b1;
        cfg_div   = 16'(n);
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        // Reset state.
        tick();
        tick();
        chk("rst_out",   32'(div_clk_out), 32'd0);
        chk("rst_div",   32'(cur_div),     32'd8);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_ready", 32'(cfg_ready),   32'd1);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Default ratio 8: rise at E0+4, fall at E0+8, pulses at E0+8 and E0+16.
        div_en = 1'b1;
        tick();                                    // E0
        chk("t1_busy", 32'(busy), 32'd1);
        repeat (3) tick();                         // E0+3
        chk("t1_low3", 32'(div_clk_out), 32'd0);
        tick();                                    // E0+4
        chk("t1_rise", 32'(div_clk_out), 32'd1);
        repeat (4) tick();                         // E0+8
        chk("t1_fall", 32'(div_clk_out), 32'd0);
        chk("t1_pd8",  32'(period_done), 32'd1);
        repeat (8) tick();                         // E0+16
        chk("t1_pd16", 32'(period_done), 32'd1);

        // Ratio 4 sent mid-high-phase; applies at the next fall.
        repeat (5) tick();                         // position 5, high
        send(4);                                   // position 6, pending
        chk("t2_ready", 32'(cfg_ready), 32'd0);
        chk("t2_div8",  32'(cur_div),   32'd8);
        repeat (2) tick();                         // boundary
        chk("t2_div4",  32'(cur_div),   32'd4);
        chk("t2_pd",    32'(period_done), 32'd1);
        repeat (2) tick();
        chk("t2_rise",  32'(div_clk_out), 32'd1);
        repeat (2) tick();
        chk("t2_fall",  32'(period_done), 32'd1);

        // Illegal ratios 7 and 0: each consumed with a one-cycle error.
        send(7);
        chk("t3_err7", 32'(cfg_err), 32'd1);
        send(0);
        chk("t3_err0", 32'(cfg_err), 32'd1);
        tick();
        chk("t3_noerr", 32'(cfg_err), 32'd0);
        chk("t3_div",   32'(cur_div), 32'd4);

        // Ratio 8 accepted in a boundary cycle waits for the following boundary.
        send(8);
        chk("t4_bpd",   32'(period_done), 32'd1);
        chk("t4_bdiv",  32'(cur_div),     32'd4);
        wait_cur(8, 10);

        // Drop div_en one cycle after a rise: high phase completes, then idle.
        wait_rise(12);
        tick();
        div_en = 1'b0;
        tick();
        chk("t4_hi6", 32'(div_clk_out), 32'd1);
        tick();
        chk("t4_hi7", 32'(div_clk_out), 32'd1);
        tick();
        chk("t4_fall", 32'(div_clk_out), 32'd0);
        chk("t4_busy", 32'(busy),        32'd0);
        repeat (10) tick();
        chk("t4_quiet", 32'(div_clk_out), 32'd0);

        // Pending ratio 2 with div_en dropped: stops with 2 in force.
        div_en = 1'b1;
        tick();
        repeat (5) tick();
        send(2);
        div_en = 1'b0;
        tick();
        tick();
        chk("t5_div2", 32'(cur_div), 32'd2);
        chk("t5_busy", 32'(busy),    32'd0);
        div_en = 1'b1;
        tick();
        chk("t5_e0",  32'(div_clk_out), 32'd0);
        tick();
        chk("t5_hi",  32'(div_clk_out), 32'd1);
        tick();
        chk("t5_lo",  32'(div_clk_out), 32'd0);
        tick();
        chk("t5_hi2", 32'(div_clk_out), 32'd1);

        // Back to 8, then reset mid-high-phase with ratio 4 pending.
        send(8);
        wait_cur(8, 6);
        wait_rise(12);
        send(4);
        chk("t6_ready0", 32'(cfg_ready), 32'd0);
        #2;
        rst_n  = 1'b0;
        div_en = 1'b0;
        #1;
        chk("t6_out",   32'(div_clk_out), 32'd0);
        chk("t6_div",   32'(cur_div),     32'd8);
        chk("t6_ready", 32'(cfg_ready),   32'd1);
        chk("t6_busy",  32'(busy),        32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_after", 32'(cur_div), 32'd8);

        // Start and ratio 6 in the same idle cycle: rise 3 cycles later.
        div_en    = 1'b1;
        cfg_valid = 1'b1;
        cfg_div   = 16'd6;
        tick();
        cfg_valid = 1'b0;
        chk("t7_div", 32'(cur_div), 32'd6);
        repeat (2) tick();
        chk("t7_low", 32'(div_clk_out), 32'd0);
        tick();
        chk("t7_rise", 32'(div_clk_out), 32'd1);
        repeat (3) tick();
        chk("t7_pd", 32'(period_done), 32'd1);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
